nrd_arbiter: RTL and testbench
==============================

NRD_ARBITER -- requirements
Module: nrd_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 32: dividend, divisor and quotient width.
REQ-002 SHALL have parameter LENW, default 7: signed length-field width.
REQ-003 SHALL have one clock; reset is asynchronous and active-low.
REQ-004 Clock and reset ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
REQ-005 Requester ports, x in {a,b}:
- req_x  in  1  request valid.
- dividend_x  in  WIDTH  dividend.
- divisor_x  in  WIDTH  divisor.
- len_dividend_x  in  LENW  signed dividend length.
- len_divisor_x  in  LENW  signed divisor length.
- gnt_x  out  1  one-cycle accept pulse.
REQ-006 Divider-side ports:
- div_dividend, div_divisor  out  WIDTH  operands.
- div_len_dividend, div_len_divisor  out  LENW  lengths.
- div_newInput  out  1  start pulse.
- div_quotient  in  WIDTH  quotient.
- div_remainder  in  WIDTH+1  signed remainder.
- div_done  in  1  divider idle/finished.
- div_numAdd, div_numSub  in  6  operation counts.
REQ-007 Result ports:
- res_valid  out  1  result available.
- res_id  out  1  0=A, 1=B.
- res_quotient  out  WIDTH.
- res_remainder  out  WIDTH+1.
- res_numAdd, res_numSub  out  6.
- res_ready  in  1  consumer accepts.
- cnt_a, cnt_b  out  8  completed-job counters.

Function
REQ-008 SHALL implement states IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, HOLD.
REQ-009 IDLE: when req_a|req_b and div_done=1, SHALL grant one requester.
- Single requester: that requester.
- Both requesting: the one not granted last.
- After reset: A wins.
REQ-010 On grant, SHALL in the same cycle pulse gnt_x for exactly one cycle, latch that requester's operands and lengths into div_* registers, and latch res_id.
REQ-011 If latched len_dividend - len_divisor < 0 (signed, LENW+1 bits), SHALL go directly to HOLD with quotient=0, remainder=zero-extended dividend, numAdd=numSub=0, and SHALL NOT pulse div_newInput.
REQ-012 Otherwise SHALL enter ISSUE and assert div_newInput=1 for exactly one cycle, then go to WAIT_BUSY.
REQ-013 WAIT_BUSY: SHALL remain until div_done=0, then go to WAIT_DONE.
REQ-014 WAIT_DONE: on div_done=1, SHALL capture div_quotient, div_remainder, div_numAdd and div_numSub into res_* registers, then go to HOLD.
REQ-015 HOLD: res_valid=1 and res_* SHALL remain stable until res_ready=1.
- The handshake cycle clears res_valid, increments the matching cnt_x (wrapping 255->0), updates the last-grant pointer and returns to IDLE.
- Earliest next grant is the following cycle.
REQ-016 SHALL issue no grant while not in IDLE; requests are level-held by requesters and are never queued.
REQ-017 div_* operand outputs SHALL hold their latched values from grant until the next grant.
REQ-018 res_ready while res_valid=0 SHALL be ignored.

Reset
REQ-019 rst_n=0 SHALL immediately and asynchronously force:
- state IDLE.
- gnt_a, gnt_b, div_newInput, res_valid: 0.
- all data outputs and cnt_a, cnt_b: 0.
- last-grant pointer: B, so A wins the first tie.
REQ-020 Reset mid-job SHALL abandon the job with no result; after release the block SHALL wait for div_done=1 before granting again.

Verification
REQ-021 Single job: A req 2020/20, lengths 11/5 -> gnt_a one cycle, div_newInput one cycle, res q=101 r=0 res_id=0, cnt_a=1.
REQ-022 Tie after reset: A 9/2 (4/2) and B 74/9 (7/4) together -> A served first (q=4 r=1), then B (q=8 r=2, res_id=1).
REQ-023 Bypass: B 10/100, lengths 4/7 -> res q=0 r=10 numAdd=numSub=0, div_newInput never asserted.
REQ-024 Backpressure: res_ready low 5 cycles in HOLD with req_b high -> res_* stable, no gnt_b until one cycle after handshake.
REQ-025 Fairness: A and B requesting continuously for 4 jobs -> grant order A,B,A,B; cnt_a=cnt_b=2.
REQ-026 Reset in WAIT_DONE -> all outputs 0 asynchronously; after release, new A 1000/1000 (10/10) -> q=1 r=0.

Source files
------------

// File: rtl/nrd_arbiter.sv
// nrd_arbiter: fair two-requester front end for a shared non-restoring divider.
// Skips the divider when the quotient is trivially zero and holds each result until it is consumed.
module nrd_arbiter #(
  parameter int WIDTH = 32,
  parameter int LENW  = 7
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req_a,
  input  logic [WIDTH-1:0]   dividend_a,
  input  logic [WIDTH-1:0]   divisor_a,
  input  logic [LENW-1:0]    len_dividend_a,
  input  logic [LENW-1:0]    len_divisor_a,
  output logic               gnt_a,
  input  logic               req_b,
  input  logic [WIDTH-1:0]   dividend_b,
  input  logic [WIDTH-1:0]   divisor_b,
  input  logic [LENW-1:0]    len_dividend_b,
  input  logic [LENW-1:0]    len_divisor_b,
  output logic               gnt_b,
  output logic [WIDTH-1:0]   div_dividend,
  output logic [WIDTH-1:0]   div_divisor,
  output logic [LENW-1:0]    div_len_dividend,
  output logic [LENW-1:0]    div_len_divisor,
  output logic               div_newInput,
  input  logic [WIDTH-1:0]   div_quotient,
  input  logic [WIDTH:0]     div_remainder,
  input  logic               div_done,
  input  logic [5:0]         div_numAdd,
  input  logic [5:0]         div_numSub,
  output logic               res_valid,
  output logic               res_id,
  output logic [WIDTH-1:0]   res_quotient,
  output logic [WIDTH:0]     res_remainder,
  output logic [5:0]         res_numAdd,
  output logic [5:0]         res_numSub,
  input  logic               res_ready,
  output logic [7:0]         cnt_a,
  output logic [7:0]         cnt_b
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ISSUE     = 3'd1,
    S_WAIT_BUSY = 3'd2,
    S_WAIT_DONE = 3'd3,
    S_HOLD      = 3'd4
  } state_t;

  state_t           r_state;
  logic             r_last_b;
  logic             r_gnt_a;
  logic             r_gnt_b;
  logic             r_new_input;
  logic [WIDTH-1:0] r_dividend;
  logic [WIDTH-1:0] r_divisor;
  logic [LENW-1:0]  r_len_dividend;
  logic [LENW-1:0]  r_len_divisor;
  logic             r_res_valid;
  logic             r_res_id;
  logic [WIDTH-1:0] r_res_quotient;
  logic [WIDTH:0]   r_res_remainder;
  logic [5:0]       r_res_num_add;
  logic [5:0]       r_res_num_sub;
  logic [7:0]       r_cnt_a;
  logic [7:0]       r_cnt_b;

  logic             w_grant;
  logic             w_pick_b;
  logic             w_bypass;
  logic [WIDTH-1:0] w_sel_dividend;
  logic [WIDTH-1:0] w_sel_divisor;
  logic [LENW-1:0]  w_sel_len_dividend;
  logic [LENW-1:0]  w_sel_len_divisor;

  assign w_grant = (req_a | req_b) & div_done;
  // On a tie the requester not served last wins; r_last_b=1 therefore favours A.
  assign w_pick_b = req_b & (~req_a | ~r_last_b);

  assign w_sel_dividend     = w_pick_b ? dividend_b     : dividend_a;
  assign w_sel_divisor      = w_pick_b ? divisor_b      : divisor_a;
  assign w_sel_len_dividend = w_pick_b ? len_dividend_b : len_dividend_a;
  assign w_sel_len_divisor  = w_pick_b ? len_divisor_b  : len_divisor_a;
  // A shorter dividend than divisor means quotient 0, so the divider is skipped.
  assign w_bypass = $signed(w_sel_len_dividend) < $signed(w_sel_len_divisor);

  assign gnt_a            = r_gnt_a;
  assign gnt_b            = r_gnt_b;
  assign div_newInput     = r_new_input;
  assign div_dividend     = r_dividend;
  assign div_divisor      = r_divisor;
  assign div_len_dividend = r_len_dividend;
  assign div_len_divisor  = r_len_divisor;
  assign res_valid        = r_res_valid;
  assign res_id           = r_res_id;
  assign res_quotient     = r_res_quotient;
  assign res_remainder    = r_res_remainder;
  assign res_numAdd       = r_res_num_add;
  assign res_numSub       = r_res_num_sub;
  assign cnt_a            = r_cnt_a;
  assign cnt_b            = r_cnt_b;

  // Arbitration / job-sequencing FSM with all outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state         <= S_IDLE;
      r_last_b        <= 1'b1;
      r_gnt_a         <= 1'b0;
      r_gnt_b         <= 1'b0;
      r_new_input     <= 1'b0;
      r_dividend      <= '0;
      r_divisor       <= '0;
      r_len_dividend  <= '0;
      r_len_divisor   <= '0;
      r_res_valid     <= 1'b0;
      r_res_id        <= 1'b0;
      r_res_quotient  <= '0;
      r_res_remainder <= '0;
      r_res_num_add   <= 6'd0;
      r_res_num_sub   <= 6'd0;
      r_cnt_a         <= 8'd0;
      r_cnt_b         <= 8'd0;
    end else begin
      r_gnt_a     <= 1'b0;
      r_gnt_b     <= 1'b0;
      r_new_input <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_grant) begin
            r_gnt_a        <= ~w_pick_b;
            r_gnt_b        <= w_pick_b;
            r_res_id       <= w_pick_b;
            r_dividend     <= w_sel_dividend;
            r_divisor      <= w_sel_divisor;
            r_len_dividend <= w_sel_len_dividend;
            r_len_divisor  <= w_sel_len_divisor;
            if (w_bypass) begin
              r_res_quotient  <= '0;
              r_res_remainder <= {1'b0, w_sel_dividend};
              r_res_num_add   <= 6'd0;
              r_res_num_sub   <= 6'd0;
              r_res_valid     <= 1'b1;
              r_state         <= S_HOLD;
            end else begin
              r_new_input <= 1'b1;
              r_state     <= S_ISSUE;
            end
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_ISSUE: begin
          r_state <= S_WAIT_BUSY;
        end
        S_WAIT_BUSY: begin
          if (!div_done) begin
            r_state <= S_WAIT_DONE;
          end else begin
            r_state <= S_WAIT_BUSY;
          end
        end
        S_WAIT_DONE: begin
          if (div_done) begin
            r_res_quotient  <= div_quotient;
            r_res_remainder <= div_remainder;
            r_res_num_add   <= div_numAdd;
            r_res_num_sub   <= div_numSub;
            r_res_valid     <= 1'b1;
            r_state         <= S_HOLD;
          end else begin
            r_state <= S_WAIT_DONE;
          end
        end
        S_HOLD: begin
          if (res_ready) begin
            r_res_valid <= 1'b0;
            r_last_b    <= r_res_id;
            if (r_res_id) begin
              r_cnt_b <= r_cnt_b + 8'd1;
            end else begin
              r_cnt_a <= r_cnt_a + 8'd1;
            end
            r_state <= S_IDLE;
          end else begin
            r_state <= S_HOLD;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nrd_arbiter.sv
// tb_nrd_arbiter: directed + randomized self-checking bench with a behavioural divider
// and a job-level reference model of the arbitration and result rules.
module tb_nrd_arbiter;
  localparam int WIDTH = 32;
  localparam int LENW  = 7;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              req_a = 1'b0, req_b = 1'b0;
  logic [WIDTH-1:0]  dividend_a = '0, divisor_a = '0, dividend_b = '0, divisor_b = '0;
  logic [LENW-1:0]   len_dividend_a = '0, len_divisor_a = '0, len_dividend_b = '0, len_divisor_b = '0;
  logic              gnt_a, gnt_b;
  logic [WIDTH-1:0]  div_dividend, div_divisor;
  logic [LENW-1:0]   div_len_dividend, div_len_divisor;
  logic              div_newInput;
  logic [WIDTH-1:0]  div_quotient = '0;
  logic [WIDTH:0]    div_remainder = '0;
  logic              div_done = 1'b1;
  logic [5:0]        div_numAdd = 6'd0, div_numSub = 6'd0;
  logic              res_valid, res_id;
  logic [WIDTH-1:0]  res_quotient;
  logic [WIDTH:0]    res_remainder;
  logic [5:0]        res_numAdd, res_numSub;
  logic              res_ready = 1'b0;
  logic [7:0]        cnt_a, cnt_b;

  nrd_arbiter #(.WIDTH(WIDTH), .LENW(LENW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_a(req_a), .dividend_a(dividend_a), .divisor_a(divisor_a),
    .len_dividend_a(len_dividend_a), .len_divisor_a(len_divisor_a), .gnt_a(gnt_a),
    .req_b(req_b), .dividend_b(dividend_b), .divisor_b(divisor_b),
    .len_dividend_b(len_dividend_b), .len_divisor_b(len_divisor_b), .gnt_b(gnt_b),
    .div_dividend(div_dividend), .div_divisor(div_divisor),
    .div_len_dividend(div_len_dividend), .div_len_divisor(div_len_divisor),
    .div_newInput(div_newInput), .div_quotient(div_quotient), .div_remainder(div_remainder),
    .div_done(div_done), .div_numAdd(div_numAdd), .div_numSub(div_numSub),
    .res_valid(res_valid), .res_id(res_id), .res_quotient(res_quotient),
    .res_remainder(res_remainder), .res_numAdd(res_numAdd), .res_numSub(res_numSub),
    .res_ready(res_ready), .cnt_a(cnt_a), .cnt_b(cnt_b)
  );

  always #5 clk = ~clk;

  // Operation counts reported by the divider stand-in (arbitrary but deterministic).
  function automatic logic [5:0] f_add(input logic [31:0] dd, input logic [31:0] ds);
    logic [31:0] s;
    s = dd + ds;
    return s[5:0];
  endfunction

  function automatic logic [5:0] f_sub(input logic [31:0] dd, input logic [31:0] ds);
    logic [31:0] s;
    s = dd / ds;
    return s[5:0];
  endfunction

  // Divider stand-in: drops done after a start pulse, raises it div_lat cycles later.
  logic [31:0] dv_dd = '0, dv_ds = '0;
  int dv_cnt = 0;
  int div_lat = 3;
  always @(posedge clk) begin
    if (div_newInput) begin
      div_done <= 1'b0;
      dv_cnt   <= div_lat;
      dv_dd    <= div_dividend;
      dv_ds    <= div_divisor;
    end else if (dv_cnt > 1) begin
      dv_cnt <= dv_cnt - 1;
    end else if (dv_cnt == 1) begin
      dv_cnt        <= 0;
      div_done      <= 1'b1;
      div_quotient  <= dv_dd / dv_ds;
      div_remainder <= {1'b0, dv_dd % dv_ds};
      div_numAdd    <= f_add(dv_dd, dv_ds);
      div_numSub    <= f_sub(dv_dd, dv_ds);
    end
  end

  int n_new = 0;
  always @(posedge clk) begin
    if (div_newInput) n_new <= n_new + 1;
  end

  // Reference model state: pending requests, their operands, last winner, counters.
  logic [31:0] op_dd[2], op_ds[2];
  int          op_ld[2], op_ls[2];
  bit          pend[2];
  int          m_last = 1;
  logic [7:0]  exp_cnt[2];
  int n_chk = 0, n_pass = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic post(input int who, input logic [31:0] dd, input logic [31:0] ds,
                      input int ld, input int ls);
    op_dd[who] = dd; op_ds[who] = ds; op_ld[who] = ld; op_ls[who] = ls;
    pend[who] = 1'b1;
    if (who == 0) begin
      req_a = 1'b1; dividend_a = dd; divisor_a = ds;
      len_dividend_a = 7'(ld); len_divisor_a = 7'(ls);
    end else begin
      req_b = 1'b1; dividend_b = dd; divisor_b = ds;
      len_dividend_b = 7'(ld); len_divisor_b = 7'(ls);
    end
  endtask

  // Serve the job the model says wins next; hold = extra cycles of res_ready low in HOLD.
  task automatic serve_next(input int hold, output int w);
    int t; int nb; bit byp;
    logic [31:0] eq; logic [32:0] er; logic [5:0] ea, es;
    w   = (pend[0] && pend[1]) ? ((m_last == 1) ? 0 : 1) : (pend[0] ? 0 : 1);
    byp = op_ld[w] < op_ls[w];
    eq  = byp ? 32'd0 : op_dd[w] / op_ds[w];
    er  = byp ? {1'b0, op_dd[w]} : {1'b0, op_dd[w] % op_ds[w]};
    ea  = byp ? 6'd0 : f_add(op_dd[w], op_ds[w]);
    es  = byp ? 6'd0 : f_sub(op_dd[w], op_ds[w]);
    nb  = n_new;
    t = 0;
    while (!(gnt_a || gnt_b) && t < 200) begin @(negedge clk); t++; end
    chk("grant_seen", 64'(gnt_a | gnt_b), 64'd1);
    chk("gnt_a", 64'(gnt_a), 64'(w == 0));
    chk("gnt_b", 64'(gnt_b), 64'(w == 1));
    chk("grant_while_done", 64'(div_done), 64'd1);
    chk("div_dividend", 64'(div_dividend), 64'(op_dd[w]));
    chk("div_divisor", 64'(div_divisor), 64'(op_ds[w]));
    chk("div_len_dividend", 64'(div_len_dividend), 64'(7'(op_ld[w])));
    chk("div_len_divisor", 64'(div_len_divisor), 64'(7'(op_ls[w])));
    chk("newInput_with_gnt", 64'(div_newInput), 64'(!byp));
    if (w == 0) req_a = 1'b0; else req_b = 1'b0;
    pend[w] = 1'b0;
    @(negedge clk);
    chk("gnt_one_cycle", 64'(gnt_a | gnt_b), 64'd0);
    chk("newInput_one_cycle", 64'(div_newInput), 64'd0);
    t = 0;
    while (!res_valid && t < 200) begin @(negedge clk); t++; end
    chk("res_valid_seen", 64'(res_valid), 64'd1);
    chk("res_id", 64'(res_id), 64'(w));
    chk("res_quotient", 64'(res_quotient), 64'(eq));
    chk("res_remainder", 64'(res_remainder), 64'(er));
    chk("res_numAdd", 64'(res_numAdd), 64'(ea));
    chk("res_numSub", 64'(res_numSub), 64'(es));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_valid", 64'(res_valid), 64'd1);
      chk("hold_quotient", 64'(res_quotient), 64'(eq));
      chk("hold_remainder", 64'(res_remainder), 64'(er));
      chk("hold_no_gnt", 64'(gnt_a | gnt_b), 64'd0);
    end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    chk("res_valid_cleared", 64'(res_valid), 64'd0);
    chk("handshake_no_gnt", 64'(gnt_a | gnt_b), 64'd0);
    chk("newInput_count", 64'(n_new - nb), 64'(byp ? 0 : 1));
    m_last = w;
    exp_cnt[w] = exp_cnt[w] + 8'd1;
    chk("cnt_a", 64'(cnt_a), 64'(exp_cnt[0]));
    chk("cnt_b", 64'(cnt_b), 64'(exp_cnt[1]));
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_gnt"}, 64'({gnt_a, gnt_b}), 64'd0);
    chk({tag, "_newInput"}, 64'(div_newInput), 64'd0);
    chk({tag, "_res_valid"}, 64'(res_valid), 64'd0);
    chk({tag, "_res_id"}, 64'(res_id), 64'd0);
    chk({tag, "_res_quotient"}, 64'(res_quotient), 64'd0);
    chk({tag, "_res_remainder"}, 64'(res_remainder), 64'd0);
    chk({tag, "_res_counts"}, 64'({res_numAdd, res_numSub}), 64'd0);
    chk({tag, "_div_ops"}, 64'({div_dividend, div_divisor}), 64'd0);
    chk({tag, "_div_lens"}, 64'({div_len_dividend, div_len_divisor}), 64'd0);
    chk({tag, "_cnts"}, 64'({cnt_a, cnt_b}), 64'd0);
  endtask

  initial begin
    int w; int t; int pat;
    pend[0] = 1'b0; pend[1] = 1'b0;
    exp_cnt[0] = 8'd0; exp_cnt[1] = 8'd0;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;

    // res_ready with nothing held must be ignored
    res_ready = 1'b1;
    repeat (3) @(negedge clk);
    res_ready = 1'b0;
    chk("idle_ready_cnts", 64'({cnt_a, cnt_b}), 64'd0);
    chk("idle_ready_valid", 64'(res_valid), 64'd0);

    // tie right after reset: A first, then B
    post(0, 32'd9, 32'd2, 4, 2);
    post(1, 32'd74, 32'd9, 7, 4);
    serve_next(0, w);
    serve_next(0, w);
    // single job on A
    post(0, 32'd2020, 32'd20, 11, 5);
    serve_next(0, w);
    // bypass on B
    post(1, 32'd10, 32'd100, 4, 7);
    serve_next(0, w);
    // backpressure: A held 5 cycles with B requesting, B granted one cycle after handshake
    post(0, 32'd500, 32'd7, 9, 3);
    post(1, 32'd77, 32'd5, 6, 2);
    serve_next(5, w);
    @(negedge clk);
    chk("gnt_b_after_handshake", 64'(gnt_b), 64'd1);
    serve_next(0, w);
    // fairness: both requesting continuously for 4 jobs
    post(0, $urandom, 32'($urandom_range(1, 5000)), 12, 3);
    post(1, $urandom, 32'($urandom_range(1, 5000)), 12, 3);
    for (int i = 0; i < 4; i++) begin
      serve_next(0, w);
      post(w, $urandom, 32'($urandom_range(1, 5000)), 12, 3);
    end
    // randomized mix of requesters, lengths, latencies and backpressure
    for (int i = 0; i < 16; i++) begin
      pat = int'($urandom_range(0, 2));
      if (pat != 1 && !pend[0])
        post(0, $urandom, 32'($urandom_range(1, 5000)), int'($urandom_range(0, 20)), int'($urandom_range(0, 20)));
      if (pat != 0 && !pend[1])
        post(1, $urandom, 32'($urandom_range(1, 5000)), int'($urandom_range(0, 20)), int'($urandom_range(0, 20)));
      div_lat = int'($urandom_range(2, 6));
      serve_next(int'($urandom_range(0, 3)), w);
    end
    while (pend[0] || pend[1]) serve_next(0, w);

    // reset while waiting for the divider
    div_lat = 30;
    post(0, 32'd2020, 32'd20, 11, 5);
    t = 0;
    while (!gnt_a && t < 200) begin @(negedge clk); t++; end
    chk("mid_job_grant", 64'(gnt_a), 64'd1);
    req_a = 1'b0;
    pend[0] = 1'b0;
    repeat (6) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_all_zero("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    m_last = 1;
    exp_cnt[0] = 8'd0; exp_cnt[1] = 8'd0;
    div_lat = 3;
    post(0, 32'd1000, 32'd1000, 10, 10);
    serve_next(0, w);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
